parking_lot_ctrl: RTL
=====================

Name: parking_lot_ctrl

Overview:
- Sequencing controller between the two debounced gate sensors and the occupancy display.
- Sensor a sits on the outer side of the gate and sensor b on the inner side. Both come from debounce instances upstream.
- An FSM tracks the a/b pattern to decide whether a car fully entered or fully exited, then updates a saturating occupancy counter.
- Outputs are one-cycle event ticks plus full/empty flags for the display and LED logic.

Parameters:
- MAX_CARS, 15: lot capacity; the count saturates at this value.
- CNT_W, 4: occupancy counter width; must satisfy 2^CNT_W > MAX_CARS.
- TIMEOUT_CYC, 500000000: stuck-sequence limit in clk cycles (10 s at 50 MHz); used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a  in  1  debounced outer sensor; 1 = beam blocked.
- b  in  1  debounced inner sensor; 1 = beam blocked.
- count  out  CNT_W  current occupancy, registered.
- full  out  1  count == MAX_CARS.
- empty  out  1  count == 0.
- enter_tick  out  1  one-cycle pulse per valid entry.
- exit_tick  out  1  one-cycle pulse per valid exit.
- reject_tick  out  1  one-cycle pulse on an entry while full or an exit while empty.
- timeout_tick  out  1  one-cycle pulse when a stuck sequence is aborted.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, count=0, all ticks 0. Therefore full=0, empty=1.
- Inputs a and b are already synchronous and debounced; no further synchronisation is done here. The ab notation below lists a first.
- FSM states and transitions, evaluated every clock:
  - IDLE: ab=10 -> EN1; ab=01 -> EX1; ab=00 or 11 -> stay.
  - EN1: 10 stay; 11 -> EN2; 00 or 01 -> IDLE, no count.
  - EN2: 11 stay; 01 -> EN3; 10 -> EN1; 00 -> IDLE.
  - EN3: 01 stay; 11 -> EN2; 00 -> IDLE plus entry event; 10 -> IDLE, no count.
  - EX1: 01 stay; 11 -> EX2; 00 or 10 -> IDLE.
  - EX2: 11 stay; 10 -> EX3; 01 -> EX1; 00 -> IDLE.
  - EX3: 10 stay; 11 -> EX2; 00 -> IDLE plus exit event; 01 -> IDLE.
  - Unused encodings -> IDLE.
- Entry event, on the same edge as the EN3->IDLE transition:
  - If count < MAX_CARS: count+1 and enter_tick=1 for the following cycle.
  - Else: count unchanged and reject_tick=1 for the following cycle.
- Exit event, on the same edge as the EX3->IDLE transition:
  - If count > 0: count-1 and exit_tick=1 for the following cycle.
  - Else: count unchanged and reject_tick=1 for the following cycle.
- Latency: count and ticks are visible one clock after the sensor sample that completes the sequence.
- Tick exclusivity: at most one of enter_tick, exit_tick, reject_tick or timeout_tick is high in any cycle. Only one event is possible per transition.
- full and empty are combinational decodes of the count register only.
- Count never wraps in either direction.
- Reset asserted mid-sequence aborts the sequence: state returns to IDLE with no count change beyond the reset itself.
- Back-steps (for example EN2->EN1) model a car reversing; they produce no event.

Optional Feature:
- Macro: PARK_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYC+1)-bit watchdog counter clears on every state change and whenever state=IDLE, and increments otherwise.
  - When it reaches TIMEOUT_CYC-1 while the state is unchanged, the next edge forces IDLE and timeout_tick=1 for one cycle. Count is unchanged.
  - The watchdog counter is reset to 0 by reset_n.
- Not defined: no watchdog logic; timeout_tick is tied to 0. The FSM can remain in a non-IDLE state indefinitely.

Test Plan:
- Reset release, then full entry ab=00,10,11,01,00 (each held 3 cycles) -> count 0->1 one cycle after the final 00, enter_tick high 1 cycle, empty 1->0.
- Exit sequence ab=00,01,11,10,00 from count=1 -> count=0, exit_tick pulse, empty=1. Repeat the exit at count=0 -> reject_tick pulse, count stays 0.
- MAX_CARS=3: four full entries -> count=3 and full=1 after the third; the fourth gives reject_tick with count held at 3.
- Aborted entry ab=10,11,10,00 (reversal) and a pedestrian pattern ab=10,00 -> no ticks, count unchanged, state back to IDLE.
- reset_n pulsed low while in EN2 with count=2 -> count=0 and state=IDLE immediately (asynchronous). A new full entry after release counts correctly to 1.
- With PARK_TIMEOUT_EN and TIMEOUT_CYC=8: hold ab=11 from EN2 -> timeout_tick after 8 cycles in EN2, state=IDLE, count unchanged. Without the macro: same stimulus gives no tick.

Source files
------------

// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl
//   Gate sequencing controller. Tracks the pattern of the outer (a) and inner
//   (b) debounced beam sensors. It decides whether a car fully entered or
//   fully exited, and keeps a saturating occupancy count.
//
// Optional feature (macro PARK_TIMEOUT_EN):
//   When defined, a watchdog aborts any non-IDLE state that holds for
//   TIMEOUT_CYC cycles. It returns the FSM to IDLE and pulses timeout_tick.
//   When undefined, timeout_tick is tied low and the FSM can wait indefinitely.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   a            in   outer sensor, 1 = beam blocked
//   b            in   inner sensor, 1 = beam blocked
//   count        out  registered occupancy [CNT_W]
//   full         out  count == MAX_CARS
//   empty        out  count == 0
//   enter_tick   out  one-cycle pulse per counted entry
//   exit_tick    out  one-cycle pulse per counted exit
//   reject_tick  out  one-cycle pulse on entry while full / exit while empty
//   timeout_tick out  one-cycle pulse when a stuck sequence is aborted
module parking_lot_ctrl #(
  parameter int MAX_CARS    = 15,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             enter_tick,
  output logic             exit_tick,
  output logic             reject_tick,
  output logic             timeout_tick
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CARS);

  // Reject configurations where the counter cannot hold MAX_CARS,
  // or where the watchdog limit is meaningless.
  if ((2 ** CNT_W) <= MAX_CARS || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("parking_lot_ctrl: need 2**CNT_W > MAX_CARS and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } state_t;

  state_t     state, state_nxt, state_go;
  logic       entry_ev, exit_ev;
  logic [1:0] ab;

  assign ab = {a, b};

  // Next-state decode. entry_ev/exit_ev flag the completing transitions.
  always_comb begin
    state_nxt = state;
    entry_ev  = 1'b0;
    exit_ev   = 1'b0;
    case (state)
      IDLE: case (ab)
              2'b10:   state_nxt = EN1;
              2'b01:   state_nxt = EX1;
              default: state_nxt = IDLE;
            endcase
      EN1:  case (ab)
              2'b10:   state_nxt = EN1;
              2'b11:   state_nxt = EN2;
              default: state_nxt = IDLE;
            endcase
      EN2:  case (ab)
              2'b11:   state_nxt = EN2;
              2'b01:   state_nxt = EN3;
              2'b10:   state_nxt = EN1;
              default: state_nxt = IDLE;
            endcase
      EN3:  case (ab)
              2'b01:   state_nxt = EN3;
              2'b11:   state_nxt = EN2;
              2'b00: begin
                state_nxt = IDLE;
                entry_ev  = 1'b1;
              end
              default: state_nxt = IDLE;
            endcase
      EX1:  case (ab)
              2'b01:   state_nxt = EX1;
              2'b11:   state_nxt = EX2;
              default: state_nxt = IDLE;
            endcase
      EX2:  case (ab)
              2'b11:   state_nxt = EX2;
              2'b10:   state_nxt = EX3;
              2'b01:   state_nxt = EX1;
              default: state_nxt = IDLE;
            endcase
      EX3:  case (ab)
              2'b10:   state_nxt = EX3;
              2'b11:   state_nxt = EX2;
              2'b00: begin
                state_nxt = IDLE;
                exit_ev   = 1'b1;
              end
              default: state_nxt = IDLE;
            endcase
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PARK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] wdog;
  logic            timeout_hit;

  // Abort only when the FSM would otherwise stay put. A pending change always
  // wins, so a timeout never coincides with an entry or exit event.
  assign timeout_hit = (state != IDLE) && (state_nxt == state) && (wdog == TO_LAST);
  assign state_go    = timeout_hit ? IDLE : state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog         <= '0;
      timeout_tick <= 1'b0;
    end else begin
      timeout_tick <= timeout_hit;
      if (state == IDLE || state_go != state) wdog <= '0;
      else                                    wdog <= wdog + 1'b1;
    end
  end
`else
  assign state_go     = state_nxt;
  assign timeout_tick = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      enter_tick  <= 1'b0;
      exit_tick   <= 1'b0;
      reject_tick <= 1'b0;
    end else begin
      state       <= state_go;
      enter_tick  <= entry_ev && (count < MAX_CNT);
      exit_tick   <= exit_ev && (count != '0);
      reject_tick <= (entry_ev && (count >= MAX_CNT)) || (exit_ev && (count == '0));
      // Saturating update: the count never wraps in either direction.
      if (entry_ev && (count < MAX_CNT))   count <= count + 1'b1;
      else if (exit_ev && (count != '0))   count <= count - 1'b1;
    end
  end

  assign full  = (count == MAX_CNT);
  assign empty = (count == '0);

endmodule
